// File: rtl/router_sync_mp_if.sv
// router_sync_mp_if: bundles the router-side handshake and status signals.
//   slave  : the router's view (address/FIFO status in, write enables/status out)
//   master : the driving side (sequencer FSM, FIFOs, status reader)
// Signals:
//   data_in, detect_add      destination address and its capture strobe
//   write_enb_reg            request to write the current byte
//   full, empty, read_enb    per-port FIFO status and downstream read strobes
//   clr_status               clears the sticky timeout flags
//   write_enb, fifo_full     one-hot write enable and selected-port full status
//   vld_out, soft_reset      per-port data-valid and one-cycle flush pulse
//   addr_err, timeout_flag   illegal-address pulse and sticky timeout record
interface router_sync_mp_if #(
  parameter int NPORTS = 3,
  parameter int ADDR_W = 2
);
  logic [ADDR_W-1:0] data_in;
  logic              detect_add;
  logic              write_enb_reg;
  logic [NPORTS-1:0] full;
  logic [NPORTS-1:0] empty;
  logic [NPORTS-1:0] read_enb;
  logic              clr_status;
  logic [NPORTS-1:0] write_enb;
  logic              fifo_full;
  logic [NPORTS-1:0] vld_out;
  logic [NPORTS-1:0] soft_reset;
  logic              addr_err;
  logic [NPORTS-1:0] timeout_flag;

  modport slave (
    input  data_in, detect_add, write_enb_reg, full, empty, read_enb, clr_status,
    output write_enb, fifo_full, vld_out, soft_reset, addr_err, timeout_flag
  );

  modport master (
    output data_in, detect_add, write_enb_reg, full, empty, read_enb, clr_status,
    input  write_enb, fifo_full, vld_out, soft_reset, addr_err, timeout_flag
  );
endinterface

// File: rtl/router_sync_mp.sv
// router_sync_mp: destination-port selection and per-port stall supervision.
// Captures a destination address, steers the write enable and full status to
// the selected port, and watches every port independently for a downstream
// stall; after TIMEOUT consecutive stalled edges the port gets a one-cycle
// soft_reset pulse and its sticky timeout_flag bit is set.
// Ports:
//   clock   rising-edge clock
//   resetn  synchronous active-low reset
//   bus     router_sync_mp_if.slave (see interface header for signal list)
module router_sync_mp #(
  parameter int NPORTS  = 3,
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 8
) (
  input  logic               clock,
  input  logic               resetn,
  router_sync_mp_if.slave    bus
);

  // One extra bit so NPORTS itself is representable when 2**ADDR_W == NPORTS.
  localparam logic [ADDR_W:0] NPORTS_LIM = (ADDR_W + 1)'(NPORTS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);

  logic [ADDR_W-1:0] sel_q, sel_d;
  logic              sel_valid_q, sel_valid_d;
  logic              addr_err_q, addr_err_d;
  logic [CNT_W-1:0]  cnt_q [NPORTS];
  logic [CNT_W-1:0]  cnt_d [NPORTS];
  logic [NPORTS-1:0] soft_reset_q, soft_reset_d;
  logic [NPORTS-1:0] timeout_flag_q, timeout_flag_d;

  logic [NPORTS-1:0] vld;
  logic [NPORTS-1:0] stall;
  logic [NPORTS-1:0] write_enb_c;
  logic              fifo_full_c;

  assign vld = ~bus.empty;

  always_comb begin
    sel_d       = sel_q;
    sel_valid_d = sel_valid_q;
    addr_err_d  = 1'b0;
    if (bus.detect_add) begin
      if ({1'b0, bus.data_in} < NPORTS_LIM) begin
        sel_d       = bus.data_in;
        sel_valid_d = 1'b1;
      end else begin
        sel_valid_d = 1'b0;
        addr_err_d  = 1'b1;
      end
    end
  end

  // A port under flush is not counted as stalled, so the count restarts
  // cleanly on the edge after the pulse.
  always_comb begin
    stall        = vld & ~bus.read_enb & ~soft_reset_q;
    soft_reset_d = '0;
    for (int i = 0; i < NPORTS; i++) begin
      cnt_d[i] = '0;
      if (stall[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          soft_reset_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    // A new pulse overrides a simultaneous clear.
    timeout_flag_d = (bus.clr_status ? '0 : timeout_flag_q) | soft_reset_d;
  end

  // Gated by resetn so the outputs are quiet during the first reset cycle too.
  always_comb begin
    write_enb_c = '0;
    fifo_full_c = 1'b0;
    for (int i = 0; i < NPORTS; i++) begin
      if (resetn && sel_valid_q && (sel_q == ADDR_W'(i))) begin
        write_enb_c[i] = bus.write_enb_reg;
        fifo_full_c    = bus.full[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      sel_q          <= '0;
      sel_valid_q    <= 1'b0;
      addr_err_q     <= 1'b0;
      soft_reset_q   <= '0;
      timeout_flag_q <= '0;
      for (int i = 0; i < NPORTS; i++) cnt_q[i] <= '0;
    end else begin
      sel_q          <= sel_d;
      sel_valid_q    <= sel_valid_d;
      addr_err_q     <= addr_err_d;
      soft_reset_q   <= soft_reset_d;
      timeout_flag_q <= timeout_flag_d;
      for (int i = 0; i < NPORTS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.write_enb    = write_enb_c;
  assign bus.fifo_full    = fifo_full_c;
  assign bus.vld_out      = vld;
  assign bus.soft_reset   = soft_reset_q;
  assign bus.addr_err     = addr_err_q;
  assign bus.timeout_flag = timeout_flag_q;

endmodule

// File: tb/tb_router_sync_mp.sv
module tb_router_sync_mp;

  logic clock = 1'b0;
  logic resetn;
  int   n_vec = 0;
  int   n_bad = 0;
  logic [2:0] seen;

  always #5 clock = ~clock;

  router_sync_mp_if #(.NPORTS(3), .ADDR_W(2)) bus ();

  router_sync_mp #(.NPORTS(3), .ADDR_W(2), .TIMEOUT(30), .CNT_W(8)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs changed afterwards are stable well before the next edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Advance n edges, accumulating any soft_reset activity into seen.
  task automatic run_ticks(input int n);
    seen = '0;
    for (int k = 0; k < n; k++) begin
      tick();
      seen |= bus.soft_reset;
    end
  endtask

  initial begin
    resetn            = 1'b0;
    bus.data_in       = '0;
    bus.detect_add    = 1'b0;
    bus.write_enb_reg = 1'b1;
    bus.full          = 3'b111;
    bus.empty         = 3'b101;
    bus.read_enb      = '0;
    bus.clr_status    = 1'b0;
    #1;
    check_val("rst_wenb_pre", 8'(bus.write_enb), 8'b000);
    check_val("rst_full_pre", 8'(bus.fifo_full), 8'b0);
    tick();
    tick();
    check_val("rst_wenb", 8'(bus.write_enb), 8'b000);
    check_val("rst_ffull", 8'(bus.fifo_full), 8'b0);
    check_val("rst_vld", 8'(bus.vld_out), 8'b010);
    check_val("rst_sreset", 8'(bus.soft_reset), 8'b000);
    check_val("rst_aerr", 8'(bus.addr_err), 8'b0);
    check_val("rst_tflag", 8'(bus.timeout_flag), 8'b000);

    // Select port 1
    bus.write_enb_reg = 1'b0;
    bus.full          = 3'b000;
    bus.empty         = 3'b111;
    resetn            = 1'b1;
    tick();
    bus.write_enb_reg = 1'b1;
    check_val("nosel_wenb", 8'(bus.write_enb), 8'b000);
    bus.write_enb_reg = 1'b0;
    bus.detect_add    = 1'b1;
    bus.data_in       = 2'd1;
    tick();
    bus.detect_add    = 1'b0;
    bus.data_in       = 2'd3;
    #1;
    check_val("sel1_wenb_idle", 8'(bus.write_enb), 8'b000);
    bus.write_enb_reg = 1'b1;
    #1;
    check_val("sel1_wenb", 8'(bus.write_enb), 8'b010);
    bus.full = 3'b010;
    #1;
    check_val("sel1_ffull", 8'(bus.fifo_full), 8'b1);
    bus.full = 3'b101;
    #1;
    check_val("sel1_ffull_other", 8'(bus.fifo_full), 8'b0);
    tick();
    check_val("sel1_hold", 8'(bus.write_enb), 8'b010);
    check_val("sel1_no_aerr", 8'(bus.addr_err), 8'b0);

    // Port 2 selection
    bus.detect_add = 1'b1;
    bus.data_in    = 2'd2;
    tick();
    bus.detect_add = 1'b0;
    #1;
    check_val("sel2_wenb", 8'(bus.write_enb), 8'b100);

    // Illegal address
    bus.detect_add = 1'b1;
    bus.data_in    = 2'd3;
    bus.full       = 3'b111;
    tick();
    bus.detect_add = 1'b0;
    #1;
    check_val("bad_aerr", 8'(bus.addr_err), 8'b1);
    check_val("bad_wenb", 8'(bus.write_enb), 8'b000);
    check_val("bad_ffull", 8'(bus.fifo_full), 8'b0);
    tick();
    check_val("bad_aerr_pulse", 8'(bus.addr_err), 8'b0);
    check_val("bad_wenb_hold", 8'(bus.write_enb), 8'b000);
    bus.write_enb_reg = 1'b0;
    bus.full          = 3'b000;

    // Port 2 stall timeout
    bus.empty = 3'b011;
    run_ticks(29);
    check_val("p2_no_early", 8'(seen), 8'b000);
    tick();
    check_val("p2_pulse", 8'(bus.soft_reset), 8'b100);
    check_val("p2_flag", 8'(bus.timeout_flag), 8'b100);
    tick();
    check_val("p2_pulse_end", 8'(bus.soft_reset), 8'b000);
    bus.empty = 3'b111;
    run_ticks(5);
    check_val("p2_flag_sticky", 8'(bus.timeout_flag), 8'b100);
    bus.clr_status = 1'b1;
    tick();
    bus.clr_status = 1'b0;
    check_val("p2_flag_clr", 8'(bus.timeout_flag), 8'b000);

    // Ports 0 and 2 together with port 1 selected
    bus.detect_add = 1'b1;
    bus.data_in    = 2'd1;
    tick();
    bus.detect_add = 1'b0;
    bus.empty      = 3'b010;
    run_ticks(29);
    check_val("p02_no_early", 8'(seen), 8'b000);
    tick();
    check_val("p02_pulse", 8'(bus.soft_reset), 8'b101);
    check_val("p02_flag", 8'(bus.timeout_flag), 8'b101);
    bus.empty = 3'b111;
    tick();
    check_val("p02_pulse_end", 8'(bus.soft_reset), 8'b000);

    // Set wins over clear on the same edge
    bus.empty = 3'b101;
    run_ticks(29);
    check_val("p1_no_early", 8'(seen), 8'b000);
    bus.clr_status = 1'b1;
    tick();
    bus.clr_status = 1'b0;
    bus.empty      = 3'b111;
    check_val("p1_pulse", 8'(bus.soft_reset), 8'b010);
    check_val("set_wins", 8'(bus.timeout_flag), 8'b010);
    tick();
    bus.clr_status = 1'b1;
    tick();
    bus.clr_status = 1'b0;
    check_val("flag_clr2", 8'(bus.timeout_flag), 8'b000);

    // read_enb on the 30th stalled edge suppresses the pulse and clears the count
    bus.empty = 3'b110;
    run_ticks(29);
    check_val("rd_no_early", 8'(seen), 8'b000);
    bus.read_enb = 3'b001;
    tick();
    bus.read_enb = 3'b000;
    check_val("rd_wins", 8'(bus.soft_reset), 8'b000);
    run_ticks(29);
    check_val("rd_fresh_count", 8'(seen), 8'b000);
    tick();
    check_val("rd_then_pulse", 8'(bus.soft_reset), 8'b001);
    bus.empty = 3'b111;
    tick();

    // Reset mid-count discards the count
    bus.clr_status = 1'b1;
    tick();
    bus.clr_status = 1'b0;
    bus.empty = 3'b110;
    run_ticks(20);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check_val("rst_mid_nopulse", 8'(bus.soft_reset | seen), 8'b000);
    run_ticks(29);
    check_val("rst_fresh_count", 8'(seen), 8'b000);
    tick();
    check_val("rst_then_pulse", 8'(bus.soft_reset), 8'b001);
    check_val("rst_then_flag", 8'(bus.timeout_flag), 8'b001);
    check_val("rst_sel_cleared", 8'(bus.write_enb), 8'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
